vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Video timing generator: pixel-clock-enable divider, run/stop FSM and registered
// position, sync, data-enable and frame-marker outputs, all in one clock domain.
//
// state    | meaning
// S_IDLE   | not scanning, position parked at (0,0), waiting for tick && run
// S_RUN    | scanning, frames repeat indefinitely
// S_STOP   | scanning, will park at the end of the current frame unless run returns
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int POS_W    = 14,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               px_ce,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);

  // Bounds are one bit wider so an interval ending exactly at 2^POS_W does not wrap.
  localparam logic [POS_W:0] H_DE_END = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0] V_DE_END = (POS_W+1)'(V_ACTIVE);
  localparam logic [POS_W:0] HS_LO    = (POS_W+1)'(H_ACTIVE + H_FP);
  localparam logic [POS_W:0] HS_HI    = (POS_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W:0] VS_LO    = (POS_W+1)'(V_ACTIVE + V_FP);
  localparam logic [POS_W:0] VS_HI    = (POS_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (POS_W < 1 || POS_W > 30) begin : g_bad_pos_w
    $error("vga_timing_gen: POS_W out of supported range 1..30");
  end
  if (longint'(H_TOTAL - 1) >= (longint'(1) << POS_W)) begin : g_bad_h
    $error("vga_timing_gen: POS_W too narrow for H_TOTAL-1");
  end
  if (longint'(V_TOTAL - 1) >= (longint'(1) << POS_W)) begin : g_bad_v
    $error("vga_timing_gen: POS_W too narrow for V_TOTAL-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  logic [POS_W-1:0] h_d;
  logic [POS_W-1:0] v_d;
  logic             ce_d;
  logic             ls_d;
  logic             fs_d;
  logic             cnt_inc;
  logic             busy_d;
  logic             hs_act;
  logic             vs_act;
  logic             de_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    h_d     = hpos;
    v_d     = vpos;
    ce_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && run) begin
          state_d = S_RUN;
          h_d     = '0;
          v_d     = '0;
          ce_d    = 1'b1;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      S_RUN, S_STOP: begin
        state_d = run ? S_RUN : S_STOP;
        if (tick) begin
          ce_d = 1'b1;
          if (hpos == H_LAST) begin
            h_d  = '0;
            ls_d = 1'b1;
            if (vpos == V_LAST) begin
              v_d = '0;
              // A stop request still pending at the last pixel parks the scan.
              if (state_q == S_STOP && !run) begin
                state_d = S_IDLE;
                ce_d    = 1'b0;
                ls_d    = 1'b0;
              end else begin
                fs_d    = 1'b1;
                cnt_inc = 1'b1;
              end
            end else begin
              v_d = vpos + 1'b1;
            end
          end else begin
            h_d = hpos + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    hs_act = ({1'b0, h_d} >= HS_LO) && ({1'b0, h_d} < HS_HI);
    vs_act = ({1'b0, v_d} >= VS_LO) && ({1'b0, v_d} < VS_HI);
    de_d   = busy_d && ({1'b0, h_d} < H_DE_END) && ({1'b0, v_d} < V_DE_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      px_ce       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= tick ? '0 : div_q + 1'b1;
      hpos        <= h_d;
      vpos        <= v_d;
      hsync       <= (busy_d && hs_act) ? H_POL : ~H_POL;
      vsync       <= (busy_d && vs_act) ? V_POL : ~V_POL;
      de          <= de_d;
      px_ce       <= ce_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      frame_cnt   <= frame_cnt + FRAME_W'(cnt_inc);
      busy        <= busy_d;
    end
  end

endmodule
